// File: rtl/acc_pkg.sv
// Shared definitions for the partial-sum accumulator: beat field layout,
// accumulator width, int8 limits and the requantization function.
package acc_pkg;

    localparam int ACC_W = 32;

    // Beat metadata field positions
    localparam int INFO_PIX_LSB = 0;
    localparam int INFO_PIX_W   = 16;
    localparam int INFO_OCH_LSB = 16;
    localparam int INFO_OCH_W   = 8;
    localparam int INFO_FIRST   = 24;
    localparam int INFO_LAST    = 25;

    // Beat data field slices: {identity s8, psum_1x1 s24, psum_3x3 s32}
    localparam int D_3X3_LSB = 0;
    localparam int D_3X3_W   = 32;
    localparam int D_1X1_LSB = 32;
    localparam int D_1X1_W   = 24;
    localparam int D_ID_LSB  = 56;
    localparam int D_ID_W    = 8;

    // int8 saturation limits
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    // Sum of the three branches of one beat, wrapping mod 2^32.
    function automatic logic [ACC_W-1:0] beat_sum(input logic [63:0] d);
        logic [D_3X3_W-1:0] p3;
        logic [D_1X1_W-1:0] p1;
        logic [D_ID_W-1:0]  id;
        p3 = d[D_3X3_LSB +: D_3X3_W];
        p1 = d[D_1X1_LSB +: D_1X1_W];
        id = d[D_ID_LSB  +: D_ID_W];
        return p3 + {{(ACC_W-D_1X1_W){p1[D_1X1_W-1]}}, p1}
                  + {{(ACC_W-D_ID_W){id[D_ID_W-1]}}, id};
    endfunction

    // Optional ReLU, arithmetic right shift (floor), then clamp to int8.
    function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] acc,
                                           input logic                    relu,
                                           input logic [4:0]              shift);
        logic signed [ACC_W-1:0] v;
        logic signed [ACC_W-1:0] s;
        v = (relu && acc < 0) ? '0 : acc;
        s = v >>> shift;
        if (s > SAT_MAX)      return 8'h7F;
        else if (s < SAT_MIN) return 8'h80;
        else                  return s[7:0];
    endfunction

endpackage

// File: rtl/psum_acc_if.sv
// Beat stream from the MAC array plus the output-map write channel.
// master = surrounding system (MAC array and output-map writer),
// slave  = the accumulator.
interface psum_acc_if;

    logic [31:0] mac_array2psum_acc_info;
    logic [63:0] mac_array2psum_acc_data;
    logic        mac_array2psum_acc_vld;
    logic        mac_array2psum_acc_rdy;
    logic [23:0] omap_waddr;
    logic [7:0]  omap_wdata;
    logic        omap_wvld;
    logic        omap_wrdy;

    modport master (
        output mac_array2psum_acc_info, mac_array2psum_acc_data, mac_array2psum_acc_vld,
        input  mac_array2psum_acc_rdy,
        input  omap_waddr, omap_wdata, omap_wvld,
        output omap_wrdy
    );

    modport slave (
        input  mac_array2psum_acc_info, mac_array2psum_acc_data, mac_array2psum_acc_vld,
        output mac_array2psum_acc_rdy,
        output omap_waddr, omap_wdata, omap_wvld,
        input  omap_wrdy
    );

endinterface

// File: rtl/psum_acc_buf.sv
// Per-pixel accumulator buffer: simple dual-port RAM, synchronous read,
// single-cycle write. Read-during-write returns the old word.
module psum_acc_buf #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    // NOTE: storage has no reset so it maps onto block RAM; every pixel's
    // first pass overwrites its word before it is ever read back.
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // Registered read port; holds its output when no read is issued
    always_ff @(posedge clk) begin
        if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/psum_acc.sv
// Partial-sum accumulator: S0 accepts a beat and issues the buffer read,
// S1 accumulates and writes back, S2 holds the requantized output.
module psum_acc
    import acc_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    psum_acc_if.slave   bus,
    input  logic [4:0]  cfg_shift,
    input  logic        cfg_relu,
    output logic        acc_busy
);

    logic              w_stall;
    logic              w_accept;
    logic [ACC_W-1:0]  w_rd_data;
    logic [ACC_W-1:0]  w_old;
    logic [ACC_W-1:0]  w_acc;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_s1_addr;
    logic              w_s1_out;
    logic              w_unused_info;

    logic                  r_s1_vld;
    logic [INFO_PIX_W-1:0] r_s1_pix;
    logic [INFO_OCH_W-1:0] r_s1_och;
    logic                  r_s1_first;
    logic                  r_s1_last;
    logic [ACC_W-1:0]      r_s1_sum;

    logic                  r_wr_vld;     // S1 wrote the buffer last cycle
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [ACC_W-1:0]      r_wr_data;

    logic                  r_hold_vld;   // S1 operand frozen across a stall
    logic [ACC_W-1:0]      r_hold_data;

    logic                  r_s2_vld;
    logic [23:0]           r_s2_addr;
    logic [7:0]            r_s2_data;

    assign w_stall  = r_s2_vld & ~bus.omap_wrdy;
    assign w_accept = bus.mac_array2psum_acc_vld & ~w_stall;
    assign bus.mac_array2psum_acc_rdy = ~w_stall;

    assign w_unused_info = ^bus.mac_array2psum_acc_info[31:INFO_LAST+1];

    assign w_s1_addr = r_s1_pix[ADDR_W-1:0];
    assign w_s1_out  = r_s1_vld & r_s1_last;

    // Old accumulator value: frozen copy during a stall, else the word S1
    // wrote last cycle (the RAM read issued alongside it returned the stale
    // word), else the RAM read data.
    assign w_old = r_hold_vld ? r_hold_data :
                   (r_wr_vld && r_wr_addr == w_s1_addr) ? r_wr_data : w_rd_data;
    assign w_acc   = r_s1_first ? r_s1_sum : (w_old + r_s1_sum);
    assign w_wr_en = r_s1_vld & ~w_stall;

    psum_acc_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (ACC_W)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_s1_addr),
        .i_wr_data (w_acc),
        .i_rd_en   (w_accept),
        .i_rd_addr (bus.mac_array2psum_acc_info[INFO_PIX_LSB +: ADDR_W]),
        .o_rd_data (w_rd_data)
    );

    // S1 register: capture an accepted beat, hold it while stalled
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_och   <= '0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sum   <= '0;
        end else if (!w_stall) begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_pix   <= bus.mac_array2psum_acc_info[INFO_PIX_LSB +: INFO_PIX_W];
                r_s1_och   <= bus.mac_array2psum_acc_info[INFO_OCH_LSB +: INFO_OCH_W];
                r_s1_first <= bus.mac_array2psum_acc_info[INFO_FIRST];
                r_s1_last  <= bus.mac_array2psum_acc_info[INFO_LAST];
                r_s1_sum   <= beat_sum(bus.mac_array2psum_acc_data);
            end
        end
    end

    // Remember the most recent buffer write for read-after-write forwarding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_vld <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= w_s1_addr;
                r_wr_data <= w_acc;
            end
        end
    end

    // Freeze S1's resolved operand on the first stalled cycle so forwarding
    // context and RAM data cannot go stale while the beat waits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
        end else if (w_stall) begin
            r_hold_vld  <= r_s1_vld;
            r_hold_data <= w_old;
        end else begin
            r_hold_vld  <= 1'b0;
        end
    end

    // S2 output register: load on a last-pass result, hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_data <= '0;
        end else if (!w_stall) begin
            r_s2_vld <= w_s1_out;
            if (w_s1_out) begin
                r_s2_addr <= {r_s1_och, r_s1_pix};
                r_s2_data <= requant($signed(w_acc), cfg_relu, cfg_shift);
            end
        end
    end

    assign bus.omap_wvld  = r_s2_vld;
    assign bus.omap_waddr = r_s2_addr;
    assign bus.omap_wdata = r_s2_data;
    assign acc_busy       = r_s1_vld | r_s2_vld;

endmodule
